// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared constants and types for the pipelined riscv core front end.
//
//   RV_XLEN     default datapath / PC width
//   RV_NOP      canonical NOP encoding (addi x0, x0, 0), used as the bubble word
//   instr_t     one 32-bit instruction word
//   imem_aw()   word-index width for an instruction memory of a given depth
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int          RV_XLEN = 32;
    localparam logic [31:0] RV_NOP  = 32'h0000_0013;

    typedef logic [31:0] instr_t;

    // Word-index width for a power-of-two memory depth. A depth of 1 still
    // gets one index bit so that slices and port widths stay legal.
    function automatic int imem_aw(input int capacity);
        return (capacity < 2) ? 1 : $clog2(capacity);
    endfunction

endpackage

// File: rtl/instr_mem.sv
// ---------------------------------------------------------------------------
// instr_mem
//   Synchronous-read instruction ROM, MEMORY_CAPACITY x 32-bit words.
//   Unloaded words read as NOP.
//
//   clk      in   1    clock
//   squash   in   1    load NOP into the read register (reset / redirect)
//   rd_en    in   1    capture mem[rd_idx] on this edge; otherwise hold
//   rd_idx   in   AW   word index
//   rd_data  out  32   registered read data
// ---------------------------------------------------------------------------
module instr_mem
    import riscv_pkg::*;
#(
    parameter int    MEMORY_CAPACITY = 256,
    parameter string INIT_FILE       = "",
    localparam int   AW              = imem_aw(MEMORY_CAPACITY)
) (
    input  logic          clk,
    input  logic          squash,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output instr_t        rd_data
);

    instr_t mem [0:MEMORY_CAPACITY-1];

    initial begin
        for (int i = 0; i < MEMORY_CAPACITY; i++) begin
            mem[i] = RV_NOP;
        end
    end

    // Squash takes precedence so a bubble never carries a stale word, and a
    // deasserted rd_en keeps the word of a stalled fetch in place.
    always_ff @(posedge clk) begin
        if (squash) begin
            rd_data <= RV_NOP;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//   IF stage: owns the PC, fetches one word per cycle from instr_mem and
//   presents {instruction, PC, PC+4, valid, misalign} to decode with a
//   one-cycle registered latency. Honours stall from the hazard unit and
//   redirect from branch/jump resolution.
//
//   clk            in   1     clock, rising edge
//   reset          in   1     synchronous, active-high
//   stall_i        in   1     hold PC and all output registers
//   redirect_i     in   1     load PC from redirect_pc_i, squash in-flight fetch
//   redirect_pc_i  in   XLEN  branch/jump target
//   RD_instr       out  32    fetched instruction word (NOP when bubble)
//   pc_o           out  XLEN  PC of RD_instr
//   pc_plus4_o     out  XLEN  pc_o + 4
//   valid_o        out  1     RD_instr is a real fetch (0 = bubble)
//   misalign_o     out  1     pc_o[1:0] != 0 for this fetch
//
//   Priority: reset > redirect_i > stall_i > advance.
// ---------------------------------------------------------------------------
module instr_fetch_stage
    import riscv_pkg::*;
#(
    parameter int                 XLEN            = RV_XLEN,
    parameter int                 MEMORY_CAPACITY = 256,
    parameter logic [XLEN-1:0]    RESET_PC        = '0,
    parameter string              INIT_FILE       = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output instr_t          RD_instr,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o,
    output logic            misalign_o
);

    localparam int AW = imem_aw(MEMORY_CAPACITY);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            advance;
    logic            squash;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_idx;

    // A fetch retires into the output registers only when nothing of higher
    // priority claims the cycle.
    assign advance   = ~reset & ~redirect_i & ~stall_i;
    assign squash    = reset | redirect_i;
    assign mem_rd_en = ~stall_i | redirect_i | reset;

    // PC bits above the memory index are ignored, so the fetch address wraps
    // around the memory; the low two bits are dropped and reported instead.
    assign mem_idx = pc_q[AW+1:2];

    // ---------------------------------------------------------------------
    // Next-PC mux
    // ---------------------------------------------------------------------
    always_comb begin
        pc_next = pc_q;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (redirect_i) begin
            pc_next = redirect_pc_i;
        end else if (!stall_i) begin
            pc_next = pc_q + XLEN'(4);   // modulo 2^XLEN
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_next;
    end

    // ---------------------------------------------------------------------
    // Instruction memory: its read register is the RD_instr output register.
    // ---------------------------------------------------------------------
    instr_mem #(
        .MEMORY_CAPACITY (MEMORY_CAPACITY),
        .INIT_FILE       (INIT_FILE)
    ) u_imem (
        .clk     (clk),
        .squash  (squash),
        .rd_en   (mem_rd_en),
        .rd_idx  (mem_idx),
        .rd_data (RD_instr)
    );

    // ---------------------------------------------------------------------
    // Output PC / valid / misalign registers
    // ---------------------------------------------------------------------
    // On a redirect pc_o keeps its last value; the bubble is identified by
    // valid_o = 0 and decode ignores pc_o while it is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_o       <= '0;
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
        end else if (redirect_i) begin
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
        end else if (advance) begin
            pc_o       <= pc_q;
            valid_o    <= 1'b1;
            misalign_o <= |pc_q[1:0];
        end
    end

    assign pc_plus4_o = pc_o + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;
    import riscv_pkg::*;

    localparam int CAP = 256;

    logic        clk = 1'b0;
    logic        reset, stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    instr_t      rd_instr;
    logic [31:0] pc_o, pc_plus4_o;
    logic        valid_o, misalign_o;

    int n_pass  = 0;
    int n_total = 0;

    // Memory image as the bench sees it, and the behavioural model state.
    logic [31:0] img [CAP];
    logic [31:0] m_pc;                 // address of the next fetch
    logic [31:0] e_instr, e_pc;        // expected outputs
    logic        e_valid, e_mis;

    instr_fetch_stage #(
        .XLEN            (32),
        .MEMORY_CAPACITY (CAP),
        .RESET_PC        (32'h0),
        .INIT_FILE       ("")
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .RD_instr      (rd_instr),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    function automatic logic [97:0] obs();
        return {rd_instr, pc_o, pc_plus4_o, valid_o, misalign_o};
    endfunction

    function automatic logic [97:0] vec(input logic [31:0] i, input logic [31:0] p,
                                        input logic v, input logic m);
        return {i, p, p + 32'd4, v, m};
    endfunction

    // Apply one cycle of inputs, advance the reference model by the
    // specification's rules, and return 1 time unit after the edge.
    task automatic step(input logic rst, input logic stl, input logic rd, input logic [31:0] tgt);
        reset = rst; stall_i = stl; redirect_i = rd; redirect_pc_i = tgt;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; e_instr = RV_NOP; e_pc = 32'h0; e_valid = 1'b0; e_mis = 1'b0;
        end else if (rd) begin
            m_pc = tgt; e_instr = RV_NOP; e_valid = 1'b0; e_mis = 1'b0;
        end else if (!stl) begin
            e_instr = img[(m_pc / 4) % CAP];
            e_pc    = m_pc;
            e_valid = 1'b1;
            e_mis   = (m_pc % 4) != 0;
            m_pc    = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            n_total++;
            if (obs() !== vec(RV_NOP, 32'h0, 1'b0, 1'b0))
                $display("FAIL reset_hold: got %h want %h", obs(), vec(RV_NOP, 32'h0, 1'b0, 1'b0));
            else n_pass++;
        end
        reset = 1'b0;
        #1;
        n_total++;
        if (valid_o !== 1'b0) $display("FAIL release_cycle0_valid: got %b want 0", valid_o);
        else n_pass++;
    endtask

    task automatic test_fetch();
        logic [31:0] wi [3];
        wi[0] = 32'h11; wi[1] = 32'h22; wi[2] = 32'h33;
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            n_total++;
            if (obs() !== vec(wi[k], 32'(k * 4), 1'b1, 1'b0))
                $display("FAIL fetch_seq[%0d]: got %h want %h", k, obs(), vec(wi[k], 32'(k * 4), 1'b1, 1'b0));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 0, 0);
            n_total++;
            if (obs() !== vec(32'h22, 32'h4, 1'b1, 1'b0))
                $display("FAIL stall_hold[%0d]: got %h want %h", k, obs(), vec(32'h22, 32'h4, 1'b1, 1'b0));
            else n_pass++;
        end
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(32'h33, 32'h8, 1'b1, 1'b0))
            $display("FAIL stall_release: got %h want %h", obs(), vec(32'h33, 32'h8, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_redirect();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0C);
        n_total++;
        if ({rd_instr, valid_o, misalign_o} !== {RV_NOP, 1'b0, 1'b0})
            $display("FAIL redirect_bubble: got %h/%b/%b want %h/0/0", rd_instr, valid_o, misalign_o, RV_NOP);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(32'h44, 32'h0C, 1'b1, 1'b0))
            $display("FAIL redirect_target: got %h want %h", obs(), vec(32'h44, 32'h0C, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_stall_redirect();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h8);
        n_total++;
        if ({rd_instr, valid_o} !== {RV_NOP, 1'b0})
            $display("FAIL stall_redirect_bubble: got %h/%b want %h/0", rd_instr, valid_o, RV_NOP);
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(32'h33, 32'h8, 1'b1, 1'b0))
            $display("FAIL stall_redirect_target: got %h want %h", obs(), vec(32'h33, 32'h8, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] tg [3];
        tg[0] = 32'h10; tg[1] = 32'h20; tg[2] = 32'h3;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, k == 1, 1, tg[k]);
            n_total++;
            if (valid_o !== 1'b0) $display("FAIL b2b_bubble[%0d]: got valid %b want 0", k, valid_o);
            else n_pass++;
        end
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(img[0], 32'h3, 1'b1, 1'b1))
            $display("FAIL b2b_last_wins: got %h want %h", obs(), vec(img[0], 32'h3, 1'b1, 1'b1));
        else n_pass++;
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 32'h3FC);
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(img[255], 32'h3FC, 1'b1, 1'b0))
            $display("FAIL wrap_word255: got %h want %h", obs(), vec(img[255], 32'h3FC, 1'b1, 1'b0));
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(img[0], 32'h400, 1'b1, 1'b0))
            $display("FAIL wrap_word0: got %h want %h", obs(), vec(img[0], 32'h400, 1'b1, 1'b0));
        else n_pass++;
        // Top of the address space: PC+4 wraps to zero.
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(img[255], 32'hFFFF_FFFC, 1'b1, 1'b0))
            $display("FAIL wrap_pc_top: got %h want %h", obs(), vec(img[255], 32'hFFFF_FFFC, 1'b1, 1'b0));
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(img[0], 32'h0, 1'b1, 1'b0))
            $display("FAIL wrap_pc_zero: got %h want %h", obs(), vec(img[0], 32'h0, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_misalign_reset();
        step(0, 0, 1, 32'h6);
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(img[1], 32'h6, 1'b1, 1'b1))
            $display("FAIL misalign_fetch: got %h want %h", obs(), vec(img[1], 32'h6, 1'b1, 1'b1));
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(img[2], 32'hA, 1'b1, 1'b1))
            $display("FAIL misalign_next: got %h want %h", obs(), vec(img[2], 32'hA, 1'b1, 1'b1));
        else n_pass++;
        step(1, 1, 1, 32'h40);
        n_total++;
        if (obs() !== vec(RV_NOP, 32'h0, 1'b0, 1'b0))
            $display("FAIL midrun_reset: got %h want %h", obs(), vec(RV_NOP, 32'h0, 1'b0, 1'b0));
        else n_pass++;
        step(0, 0, 0, 0);
        n_total++;
        if (obs() !== vec(img[0], 32'h0, 1'b1, 1'b0))
            $display("FAIL after_reset_fetch: got %h want %h", obs(), vec(img[0], 32'h0, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_random();
        logic        r, s, d;
        logic [31:0] t;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 99) < 3);
            d = ($urandom_range(0, 99) < 15);
            s = ($urandom_range(0, 99) < 25);
            case ($urandom_range(0, 3))
                0:       t = $urandom;
                1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                default: t = $urandom & 32'h0000_0FFC;
            endcase
            step(r, s, d, t);
            n_total++;
            if (e_valid) begin
                if (obs() !== vec(e_instr, e_pc, 1'b1, e_mis))
                    $display("FAIL random[%0d]: got %h want %h", k, obs(), vec(e_instr, e_pc, 1'b1, e_mis));
                else n_pass++;
            end else begin
                if ({rd_instr, valid_o, misalign_o, pc_plus4_o} !== {RV_NOP, 1'b0, 1'b0, pc_o + 32'd4})
                    $display("FAIL random_bubble[%0d]: got %h/%b/%b/%h want %h/0/0/%h",
                             k, rd_instr, valid_o, misalign_o, pc_plus4_o, RV_NOP, pc_o + 32'd4);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        m_pc = 32'h0; e_instr = RV_NOP; e_pc = 32'h0; e_valid = 1'b0; e_mis = 1'b0;
        #1;
        for (int i = 0; i < CAP; i++) begin
            img[i] = $urandom;
        end
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
        for (int i = 0; i < CAP; i++) begin
            dut.u_imem.mem[i] = img[i];
        end

        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_back_to_back();
        test_wrap();
        test_misalign_reset();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
